// File: rtl/axi_dump_pkg.sv
// Shared types and helpers for the AXI memory dump reader and its sibling loader.
// Holds the engine state encoding, AXI constants and the 4 KB page helper.
package axi_dump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_FIN
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Words between addr_lo and the next 4 KB boundary; never zero for aligned addresses.
    function automatic logic [12:0] beats_to_4k(input logic [11:0] addr_lo, input logic [2:0] size);
        logic [12:0] bytes_left;
        bytes_left = 13'h1000 - {1'b0, addr_lo};
        return bytes_left >> size;
    endfunction

endpackage

// File: rtl/axi_mem_dump_burst_calc.sv
// Burst length for the next AR: min(remaining, MAX_BURST, words to the 4 KB boundary) - 1.
// Only the page offset of the address matters, so only those bits are taken in.
module axi_mem_dump_burst_calc
    import axi_dump_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic [11:0]          addr_lo,
    input  logic [CNT_WIDTH-1:0] remaining,
    output logic [7:0]           ar_len
);

    localparam int W = (CNT_WIDTH > 14) ? CNT_WIDTH : 14;
    localparam logic [2:0] SIZE = 3'($clog2(DATA_WIDTH / 8));

    logic [W-1:0] rem_w, max_w, b4k_w, beats;

    always_comb begin
        rem_w = W'(remaining);
        max_w = W'(MAX_BURST);
        b4k_w = W'(beats_to_4k(addr_lo, SIZE));
        beats = rem_w;
        if (max_w < beats) beats = max_w;
        if (b4k_w < beats) beats = b4k_w;
        // remaining == 0 only happens while idle; keep ar_len at 0 then
        ar_len = (beats == '0) ? 8'd0 : 8'(beats - W'(1));
    end

endmodule

// File: rtl/axi_mem_dump_reader.sv
// AXI4 read initiator that walks a word range of node RAM in bursts and streams
// every word out together with its byte address; one burst outstanding at a time.
module axi_mem_dump_reader
    import axi_dump_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0,
    parameter int MAX_BURST  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ID_WIDTH-1:0]   ar_id,
    output logic [ADDR_WIDTH-1:0] ar_addr,
    output logic [7:0]            ar_len,
    output logic [2:0]            ar_size,
    output logic [1:0]            ar_burst,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    input  logic [ID_WIDTH-1:0]   r_id,
    input  logic [DATA_WIDTH-1:0] r_data,
    input  logic [1:0]            r_resp,
    input  logic                  r_last,
    input  logic                  r_valid,
    output logic                  r_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [2:0]            SIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ID_WIDTH-1:0]   ID   = ID_WIDTH'(AXI_ID);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;        // next beat address; doubles as next AR address
    logic [CNT_WIDTH-1:0]  remaining_q;
    logic [7:0]            beat_cnt_q;    // beats left in burst minus 1
    logic                  err_q;
    logic [7:0]            len_calc;
    logic                  beat, last_beat, beat_err;

    axi_mem_dump_burst_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) u_burst_calc (
        .addr_lo   (addr_q[11:0]),
        .remaining (remaining_q),
        .ar_len    (len_calc)
    );

    assign last_beat = (beat_cnt_q == 8'd0);
    assign beat_err  = (r_resp != AXI_RESP_OKAY) | (r_id != ID) | (r_last != last_beat);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        done      = 1'b0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        out_valid = 1'b0;
        beat      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = (word_count == '0) ? ST_FIN : ST_ADDR;
            end
            ST_ADDR: begin
                ar_valid = 1'b1;
                if (ar_ready) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                r_ready   = out_ready;
                out_valid = r_valid;
                beat      = r_valid & out_ready;
                // sequencing follows our own beat count, never r_last
                if (beat && last_beat)
                    state_nxt = (remaining_q == CNT_WIDTH'(1)) ? ST_FIN : ST_ADDR;
            end
            ST_FIN: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr_q      <= base_addr;
                        remaining_q <= word_count;
                        err_q       <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (ar_ready) beat_cnt_q <= len_calc;
                end
                ST_DATA: begin
                    if (beat) begin
                        addr_q      <= addr_q + STEP;
                        remaining_q <= remaining_q - CNT_WIDTH'(1);
                        beat_cnt_q  <= beat_cnt_q - 8'd1;
                        if (beat_err) err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign error    = err_q;
    assign ar_id    = ID;
    assign ar_addr  = addr_q;
    assign ar_len   = len_calc;
    assign ar_size  = SIZE;
    assign ar_burst = AXI_BURST_INCR;
    assign out_data = r_data;
    assign out_addr = addr_q;

endmodule

// File: tb/tb_axi_mem_dump_reader.sv
// Directed bench for axi_mem_dump_reader: a cycle-stepped AXI slave model feeds
// beats with data 0x11*(n+1) and the logged AR/stream traffic is compared with hand-computed values.
module tb_axi_mem_dump_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done, error;
    logic [3:0]  ar_id;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        ar_valid;
    logic        ar_ready = 1'b0;
    logic [3:0]  r_id = '0;
    logic [31:0] r_data = '0;
    logic [1:0]  r_resp = '0;
    logic        r_last = 1'b0;
    logic        r_valid = 1'b0;
    logic        r_ready;
    logic [31:0] out_data, out_addr;
    logic        out_valid;
    logic        out_ready = 1'b1;

    always #5 clk = ~clk;

    axi_mem_dump_reader #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .AXI_ID(0), .MAX_BURST(16), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done), .error(error),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready),
        .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid), .out_ready(out_ready)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // slave model and traffic logs
    int  cyc = 0, ar_delay = 0, ar_wait = 0;
    bit  toggle_rdy = 0, have_burst = 0;
    int  cur_len = 0, beat_i = 0, gidx = 0, exp_total = 0, done_cnt = 0;
    int  slverr_at = -1, early_last_at = -1, bad_id_at = -1;
    bit  pend_bubble = 0;
    int  pend_done = 0;
    bit  arw_prev = 0, stall_prev = 0;
    logic [31:0] arw_addr, stall_data, stall_addr;
    logic [7:0]  arw_len;
    logic [31:0] ar_log_addr[$], out_log_addr[$], out_log_data[$];
    int          ar_log_len[$];

    // One clock: drive at negedge, sample settled outputs 1 time unit later (pre-posedge view).
    task automatic step(input logic st, input logic rs);
        @(negedge clk);
        cyc++;
        start     = st;
        rst       = rs;
        out_ready = toggle_rdy ? cyc[0] : 1'b1;
        ar_ready  = 1'b0;
        if (ar_valid && !have_burst) begin
            if (ar_wait >= ar_delay) ar_ready = 1'b1;
            else ar_wait++;
        end
        r_valid = have_burst;
        r_data  = have_burst ? 32'h11 * (gidx + 1) : 32'h0;
        r_resp  = (have_burst && gidx == slverr_at) ? 2'b10 : 2'b00;
        r_id    = (have_burst && gidx == bad_id_at) ? 4'h3 : 4'h0;
        r_last  = have_burst && (beat_i == cur_len || gidx == early_last_at);
        #1;
        if (pend_bubble) begin chk("bubble_ar_valid", ar_valid, 1); pend_bubble = 0; end
        if (pend_done == 2) begin chk("done_k1", done, 1); pend_done = 1; end
        else if (pend_done == 1) begin chk("busy_low_k2", busy, 0); pend_done = 0; end
        if (arw_prev) begin
            chk("ar_addr_hold", ar_addr, arw_addr);
            chk("ar_len_hold", ar_len, arw_len);
        end
        arw_prev = ar_valid && !ar_ready;
        arw_addr = ar_addr;
        arw_len  = ar_len;
        if (stall_prev) begin
            chk("out_data_hold", out_data, stall_data);
            chk("out_addr_hold", out_addr, stall_addr);
        end
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        stall_addr = out_addr;
        if (ar_valid && ar_ready) begin
            ar_log_addr.push_back(ar_addr);
            ar_log_len.push_back(int'(ar_len));
            chk("ar_const", {ar_id, ar_size, ar_burst}, {4'h0, 3'd2, 2'b01});
            have_burst = 1;
            cur_len    = int'(ar_len);
            beat_i     = 0;
            ar_wait    = 0;
        end else if (r_valid && r_ready) begin
            chk("out_valid_pass", out_valid, 1);
            out_log_addr.push_back(out_addr);
            out_log_data.push_back(out_data);
            gidx++;
            beat_i++;
            if (beat_i > cur_len) begin
                have_burst = 0;
                if (gidx < exp_total) pend_bubble = 1;
                else pend_done = 2;
            end
        end
        if (done) done_cnt++;
        if (rs) begin
            have_burst = 0; ar_wait = 0; pend_bubble = 0; pend_done = 0;
            arw_prev = 0; stall_prev = 0;
        end
    endtask

    task automatic start_xfer(input logic [31:0] base, input int cnt);
        ar_log_addr.delete(); ar_log_len.delete();
        out_log_addr.delete(); out_log_data.delete();
        gidx = 0; exp_total = cnt; done_cnt = 0;
        base_addr  = base;
        word_count = 16'(cnt);
        step(1, 0);
        step(0, 0);
        chk("busy_n1", busy, 1);
        chk("ar_valid_n1", ar_valid, (cnt != 0) ? 1 : 0);
    endtask

    task automatic run_xfer(input logic [31:0] base, input int cnt);
        start_xfer(base, cnt);
        for (int i = 0; i < 2000 && done_cnt == 0; i++) step(0, 0);
        step(0, 0);
        step(0, 0);
        chk("done_pulses", done_cnt, 1);
        chk("beat_count", out_log_addr.size(), cnt);
        for (int k = 0; k < out_log_addr.size() && k < cnt; k++) begin
            chk("out_addr", out_log_addr[k], base + 32'(4 * k));
            chk("out_data", out_log_data[k], 32'h11 * (k + 1));
        end
    endtask

    task automatic chk_ar(input int n, input logic [31:0] a, input int len);
        if (ar_log_addr.size() > n) begin
            chk("ar_addr", ar_log_addr[n], a);
            chk("ar_len", ar_log_len[n], len);
        end else chk("ar_missing", ar_log_addr.size(), n + 1);
    endtask

    initial begin
        step(0, 1);
        step(0, 1);
        step(0, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_ar", {ar_valid, ar_addr, ar_len}, 41'h0);
        chk("rst_rready_ovalid", {r_ready, out_valid}, 2'b00);

        // single burst
        run_xfer(32'h100, 4);
        chk("single_nar", ar_log_addr.size(), 1);
        chk_ar(0, 32'h100, 3);
        chk("single_error", error, 0);

        // split bursts
        run_xfer(32'h0, 40);
        chk("split_nar", ar_log_addr.size(), 3);
        chk_ar(0, 32'h0, 15);
        chk_ar(1, 32'h40, 15);
        chk_ar(2, 32'h80, 7);

        // 4 KB crossing
        run_xfer(32'hFF8, 4);
        chk("cross_nar", ar_log_addr.size(), 2);
        chk_ar(0, 32'hFF8, 1);
        chk_ar(1, 32'h1000, 1);

        // back-pressure and late AR ready
        toggle_rdy = 1; ar_delay = 3;
        run_xfer(32'h300, 6);
        chk("bp_nar", ar_log_addr.size(), 1);
        chk_ar(0, 32'h300, 5);
        toggle_rdy = 0; ar_delay = 0;

        // SLVERR on beat 2, premature r_last in the second burst
        slverr_at = 1; early_last_at = 17;
        run_xfer(32'h2000, 20);
        chk("err_sticky", error, 1);
        chk_ar(0, 32'h2000, 15);
        chk_ar(1, 32'h2040, 3);
        slverr_at = -1; early_last_at = -1;

        // next start clears error
        start_xfer(32'h40, 2);
        chk("err_cleared", error, 0);
        for (int i = 0; i < 200 && done_cnt == 0; i++) step(0, 0);
        step(0, 0);
        chk("err_clean_end", error, 0);

        // premature r_last alone
        early_last_at = 1;
        run_xfer(32'h80, 4);
        chk("err_early_last", error, 1);
        early_last_at = -1;

        // wrong r_id alone
        bad_id_at = 2;
        run_xfer(32'h400, 4);
        chk("err_bad_id", error, 1);
        bad_id_at = -1;

        // zero words
        start_xfer(32'h700, 0);
        chk("zero_done_n1", done, 1);
        step(0, 0);
        chk("zero_busy_n2", busy, 0);
        chk("zero_nar", ar_log_addr.size(), 0);

        // reset during DATA
        slverr_at = 0;
        start_xfer(32'h500, 8);
        for (int i = 0; i < 200 && out_log_addr.size() < 3; i++) step(0, 0);
        chk("mid_state_data", r_ready, 1);
        step(0, 1);
        step(0, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_ar", {ar_valid, ar_addr, ar_len}, 41'h0);
        chk("mid_rst_rready_ovalid", {r_ready, out_valid}, 2'b00);
        slverr_at = -1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_mem_dump_reader.md
# axi_mem_dump_reader

AXI4 read-initiator that walks a contiguous word range of a node's coupled RAM through the mesh NoC and streams each word out with its address. It is the hardware counterpart of the simulation-side memory image load and dump flow: it lets a host or trace port extract node RAM contents at run time. It sits on a spare NoC master port, one instance per extraction point.

## Interface
- `ADDR_WIDTH`, 32: AXI byte-address width.
- `DATA_WIDTH`, 32: AXI data and word width; power of two, at least 8.
- `ID_WIDTH`, 4: AXI ID width.
- `AXI_ID`, 0: constant ID driven on `ar_id`.
- `MAX_BURST`, 16: maximum beats per burst, 1..256.
- `CNT_WIDTH`, 16: width of the word counter.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first byte address; word-aligned; sampled with `start`.
- `word_count`  in  CNT_WIDTH  number of words to read; sampled with `start`.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky; cleared when the next `start` is accepted.
- `ar_id`  out  ID_WIDTH  equal to `AXI_ID`.
- `ar_addr`  out  ADDR_WIDTH  burst start address.
- `ar_len`  out  8  beats minus 1.
- `ar_size`  out  3  log2(DATA_WIDTH/8).
- `ar_burst`  out  2  INCR (2'b01).
- `ar_valid`  out  1  AR valid.
- `ar_ready`  in  1  AR ready.
- `r_id`  in  ID_WIDTH  read ID; checked.
- `r_data`  in  DATA_WIDTH  read data.
- `r_resp`  in  2  read response.
- `r_last`  in  1  last beat of the burst.
- `r_valid`  in  1  R valid.
- `r_ready`  out  1  R ready.
- `out_data`  out  DATA_WIDTH  dumped word.
- `out_addr`  out  ADDR_WIDTH  byte address of `out_data`.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.

## Operation
- FSM states are IDLE, ADDR, DATA and FIN.
- **IDLE.** When `start` is high, latch `base_addr` and `word_count` and clear `error`.
  - If `word_count` is 0, go to FIN with no AR issued.
  - Otherwise go to ADDR.
- **Burst length.** beats = min(remaining, `MAX_BURST`, words to the next 4 KB boundary). `ar_len` = beats - 1.
- **ADDR.** `ar_valid` is high. `ar_addr`/`ar_len` are held stable until `ar_ready`; then go to DATA.
- **DATA.** The R channel passes straight through to the output stream:
  - `out_valid` = `r_valid`, `r_ready` = `out_ready`, `out_data` = `r_data`.
  - `out_addr` is a registered address counter that advances by DATA_WIDTH/8 on each beat handshake.
  - A beat is consumed on `r_valid & r_ready`. The beat and remaining counters decrement on each consumed beat.
- **End of burst.** On the final beat of a burst, go to ADDR if words remain, otherwise go to FIN.
- **FIN.** `done` is high for one cycle, then return to IDLE.
- **`error` is set, sticky, by any of:**
  - `r_resp` != OKAY on any beat;
  - `r_id` != `AXI_ID`;
  - `r_last` not matching the expected final beat.
- **Errors never stall the engine.** Data is forwarded anyway, and the engine finishes at the beat count it computed, ignoring `r_last` for sequencing.
- `start` is ignored outside IDLE.
- Address arithmetic wraps modulo 2^ADDR_WIDTH with no error.
- Only one burst is outstanding at a time; no AR is issued before the previous burst's last beat.

## Timing
- **Reset values:** state IDLE; `busy`, `done`, `error`, `ar_valid` all 0; `ar_addr` 0; `ar_len` 0.
- `r_ready` and `out_valid` are 0 whenever state is not DATA.
- `start` accepted at cycle N: `busy` and `ar_valid` are high at N+1.
- AR handshake at cycle M: state is DATA at M+1. A beat presented at M+1 can pass with zero added latency, since the data path is combinational.
- Last beat of a non-final burst at cycle K: `ar_valid` is high at K+1, so there is a one-cycle bubble between bursts.
- Last beat of the final burst at K: `done` is high at K+1 and `busy` is low at K+2.
- `word_count` = 0 accepted at N: `done` is high at N+1.
- Back-pressure: `out_ready` low holds `r_ready` low. `out_data` and `out_addr` stay stable while `out_valid & !out_ready`.
- `rst` asserted mid-transfer returns every output to its reset value on the next edge. The NoC must be reset in the same cycle; in-flight R beats are not drained.

## Structure
- **`axi_dump_pkg`** holds:
  - the state enum;
  - the `AXI_BURST_INCR` and `AXI_RESP_OKAY` constants;
  - a function returning beats-to-4 KB-boundary.
- **`axi_mem_dump_burst_calc`** is one natural combinational sub-module. Its inputs are the address, remaining count and `MAX_BURST`; its output is `ar_len`. It is reused by the planned write-side loader.

## Test plan
- **Single burst.** base 0x0000_0100, count 4, R returns 0x11..0x44 with `r_last` on beat 4. Expect:
  - one AR with len 3;
  - `out_addr` 0x100/104/108/10C;
  - `done` 1 cycle later; `error` 0.
- **Split bursts.** count 40, MAX_BURST 16. Expect three ARs with len 15, 15, 7; 40 output beats; one `done` pulse.
- **4 KB crossing.** base 0x0000_0FF8, count 4. Expect:
  - AR0 at 0xFF8 with len 1;
  - AR1 at 0x1000 with len 1.
- **Back-pressure and late ready.** `out_ready` toggles every cycle and `ar_ready` is delayed 3 cycles. Expect:
  - `ar_*` stable while waiting;
  - no beat lost or duplicated;
  - `out_data` stable while stalled.
- **Error handling.** SLVERR on beat 2, then a premature `r_last` on the next burst. Expect:
  - `error` high and staying high;
  - all beats forwarded and `done` still pulsed;
  - next `start` clears `error`.
- **Edge cases.** `word_count` 0 gives `done` at N+1 with no AR. `rst` asserted during DATA gives IDLE with all outputs 0 next cycle.
